q_readout_arbiter: RTL and testbench

Collects per-channel charge results (valid pulse plus Q value) from several charge-extractor instances and timestamps each one. Each result is buffered in a one-deep slot per channel. A round-robin arbiter serialises the slots onto a single valid/ready output stream feeding the readout FIFO. Results that arrive while their channel's slot is still occupied are dropped and counted.

---
 rtl/q_readout_arbiter.sv | 165 ++++++++++++++++
 tb/tb_q_readout_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/q_readout_arbiter.sv
// q_readout_arbiter
// Timestamps per-channel charge results, buffers each in a one-deep slot and
// serialises the slots onto one valid/ready stream using round-robin arbitration.
// A result that arrives while its slot is still occupied is dropped and counted.
//
// Ports
//   clk, reset_n          system clock, synchronous active-low reset
//   enable                1 = accept new results, 0 = ignore q_valid (slots still drain)
//   clr_stats             one-cycle pulse, zeroes all drop counters
//   q_valid, q_in         per-channel result pulse and packed signed Q values
//   out_valid, out_ready  output handshake
//   out_ch, out_q, out_ts channel, charge and capture timestamp of the output word
//   pending               slot-occupied flags
//   drop_cnt              packed per-channel saturating drop counters
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_EMPTY | output register holds no word (out_valid=0)
// ST_FULL  | output register holds a word awaiting out_ready

module q_readout_arbiter #(
   parameter int N_CH     = 4,
   parameter int BITS     = 31,
   parameter int TS_BITS  = 32,
   parameter int CNT_BITS = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     enable,
   input  logic                     clr_stats,
   input  logic [N_CH-1:0]          q_valid,
   input  logic [N_CH*BITS-1:0]     q_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [2:0]               out_ch,
   output logic [BITS-1:0]          out_q,
   output logic [TS_BITS-1:0]       out_ts,
   output logic [N_CH-1:0]          pending,
   output logic [N_CH*CNT_BITS-1:0] drop_cnt
);

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   logic [0:0]         state_q, state_d;
   logic [TS_BITS-1:0] ts_q, ts_d;
   logic [2:0]         last_grant_q, last_grant_d;
   logic [2:0]         out_ch_q, out_ch_d;
   logic [BITS-1:0]    out_q_q, out_q_d;
   logic [TS_BITS-1:0] out_ts_q, out_ts_d;
   logic [N_CH-1:0]    pend_q, pend_d;

   logic [N_CH-1:0][BITS-1:0]     slot_val_q, slot_val_d;
   logic [N_CH-1:0][TS_BITS-1:0]  slot_ts_q, slot_ts_d;
   logic [N_CH-1:0][CNT_BITS-1:0] drop_q, drop_d;

   logic               grant_found;
   logic [2:0]         grant_idx;
   logic [BITS-1:0]    grant_val;
   logic [TS_BITS-1:0] grant_ts;
   logic               load;

   // Round-robin search: first pending slot starting after the last grant.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      grant_val   = '0;
      grant_ts    = '0;
      for (int k = 1; k <= N_CH; k++) begin
         int idx;
         idx = (int'(last_grant_q) + k) % N_CH;
         if (!grant_found && pend_q[idx]) begin
            grant_found = 1'b1;
            grant_idx   = 3'(idx);
            grant_val   = slot_val_q[idx];
            grant_ts    = slot_ts_q[idx];
         end
      end
   end

   assign load = grant_found && ((state_q == ST_EMPTY) || out_ready);

   // A slot being moved to the output this cycle counts as free, so a capture
   // into it replaces the departing word instead of dropping.
   always_comb begin
      pend_d     = pend_q;
      slot_val_d = slot_val_q;
      slot_ts_d  = slot_ts_q;
      drop_d     = drop_q;
      for (int i = 0; i < N_CH; i++) begin
         logic granted;
         granted = load && (grant_idx == 3'(i));
         if (granted) begin
            pend_d[i] = 1'b0;
         end
         if (enable && q_valid[i]) begin
            if (!pend_q[i] || granted) begin
               pend_d[i]     = 1'b1;
               slot_val_d[i] = q_in[i*BITS +: BITS];
               slot_ts_d[i]  = ts_q;
            end else if (drop_q[i] != {CNT_BITS{1'b1}}) begin
               drop_d[i] = drop_q[i] + 1'b1;
            end
         end
         if (clr_stats) begin
            drop_d[i] = '0;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      out_ch_d     = out_ch_q;
      out_q_d      = out_q_q;
      out_ts_d     = out_ts_q;
      ts_d         = ts_q + 1'b1;
      if (load) begin
         state_d      = ST_FULL;
         last_grant_d = grant_idx;
         out_ch_d     = grant_idx;
         out_q_d      = grant_val;
         out_ts_d     = grant_ts;
      end else if ((state_q == ST_FULL) && out_ready) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= ST_EMPTY;
         ts_q         <= '0;
         last_grant_q <= '0;
         out_ch_q     <= '0;
         out_q_q      <= '0;
         out_ts_q     <= '0;
         pend_q       <= '0;
         slot_val_q   <= '0;
         slot_ts_q    <= '0;
         drop_q       <= '0;
      end else begin
         state_q      <= state_d;
         ts_q         <= ts_d;
         last_grant_q <= last_grant_d;
         out_ch_q     <= out_ch_d;
         out_q_q      <= out_q_d;
         out_ts_q     <= out_ts_d;
         pend_q       <= pend_d;
         slot_val_q   <= slot_val_d;
         slot_ts_q    <= slot_ts_d;
         drop_q       <= drop_d;
      end
   end

   assign out_valid = (state_q == ST_FULL);
   assign out_ch    = out_ch_q;
   assign out_q     = out_q_q;
   assign out_ts    = out_ts_q;
   assign pending   = pend_q;

   for (genvar g = 0; g < N_CH; g++) begin : g_drop
      assign drop_cnt[g*CNT_BITS +: CNT_BITS] = drop_q[g];
   end

endmodule

// File: tb/tb_q_readout_arbiter.sv
// Self-checking bench for q_readout_arbiter: directed scenarios followed by a
// randomized phase, with a queue-based scoreboard fed by a behavioural model.

module tb_q_readout_arbiter;

   localparam int N = 4;
   localparam int B = 31;
   localparam int T = 32;
   localparam int C = 16;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          enable;
   logic          clr_stats;
   logic [N-1:0]  q_valid;
   logic [N*B-1:0] q_in;
   logic          out_valid;
   logic          out_ready;
   logic [2:0]    out_ch;
   logic [B-1:0]  out_q;
   logic [T-1:0]  out_ts;
   logic [N-1:0]  pending;
   logic [N*C-1:0] drop_cnt;

   q_readout_arbiter #(.N_CH(N), .BITS(B), .TS_BITS(T), .CNT_BITS(C)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .clr_stats(clr_stats),
      .q_valid(q_valid), .q_in(q_in), .out_valid(out_valid), .out_ready(out_ready),
      .out_ch(out_ch), .out_q(out_q), .out_ts(out_ts), .pending(pending),
      .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   int errs   = 0;
   int checks = 0;
   int hs_cnt = 0;

   typedef struct {
      int         ch;
      logic [B-1:0] q;
      logic [T-1:0] ts;
   } word_t;

   word_t exp_q[$];

   // Behavioural model: slots, output occupancy, rr pointer, counters.
   bit           m_pend[N];
   logic [B-1:0] m_sq[N];
   logic [T-1:0] m_sts[N];
   int           m_drop[N];
   bit           m_full = 0;
   int           m_last = 0;
   logic [T-1:0] m_ts = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [B-1:0] q31(input int v);
      return v[B-1:0];
   endfunction

   // Model advances at the negedge using this cycle's inputs; its state then
   // describes what the DUT holds after the following posedge.
   always @(negedge clk) begin : model_p
      bit ld;
      int g;
      int c;
      word_t w;
      if (!reset_n) begin
         for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; m_drop[i] = 0; m_sq[i] = '0; m_sts[i] = '0;
         end
         m_full = 0; m_last = 0; m_ts = '0;
         exp_q.delete();
      end else begin
         ld = 0; g = 0;
         if (!m_full || out_ready) begin
            for (int k = 1; k <= N; k++) begin
               c = (m_last + k) % N;
               if (!ld && m_pend[c]) begin ld = 1; g = c; end
            end
         end
         if (ld) begin
            w.ch = g; w.q = m_sq[g]; w.ts = m_sts[g];
            exp_q.push_back(w);
            m_pend[g] = 0;
            m_full = 1;
            m_last = g;
         end else if (m_full && out_ready) begin
            m_full = 0;
         end
         for (int i = 0; i < N; i++) begin
            if (enable && q_valid[i]) begin
               if (!m_pend[i]) begin
                  m_pend[i] = 1;
                  m_sq[i] = q_in[i*B +: B];
                  m_sts[i] = m_ts;
               end else if (m_drop[i] < 65535) begin
                  m_drop[i]++;
               end
            end
            if (clr_stats) m_drop[i] = 0;
         end
         m_ts = m_ts + 1;
      end
   end

   // Monitor: every accepted output word is matched against the scoreboard.
   always @(negedge clk) begin : monitor_p
      word_t w;
      if (reset_n && out_valid && out_ready) begin
         hs_cnt++;
         if (exp_q.size() == 0) begin
            chk("unexpected_word", {61'd0, out_ch}, 64'hFFFF);
         end else begin
            w = exp_q.pop_front();
            chk("sb_ch", 64'(out_ch), 64'(w.ch));
            chk("sb_q", 64'(out_q), 64'(w.q));
            chk("sb_ts", 64'(out_ts), 64'(w.ts));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      q_valid = '0;
      clr_stats = 1'b0;
      tick();
      reset_n = 1'b1;
   endtask

   task automatic set_q(input int ch, input int v);
      q_in[ch*B +: B] = v[B-1:0];
   endtask

   task automatic check_state(input string tag);
      logic [63:0] ed;
      logic [63:0] ep;
      ed = '0; ep = '0;
      for (int i = 0; i < N; i++) begin
         ed[i*C +: C] = 16'(m_drop[i]);
         ep[i] = m_pend[i];
      end
      chk({tag, "_pending"}, 64'(pending), ep);
      chk({tag, "_drop"}, 64'(drop_cnt), ed);
      chk({tag, "_valid"}, 64'(out_valid), 64'(m_full));
   endtask

   initial begin
      int hs0;
      int chs[4];
      int guard;
      reset_n = 1'b0; enable = 1'b1; clr_stats = 1'b0;
      q_valid = '0; q_in = '0; out_ready = 1'b1;
      tick(); tick();
      reset_n = 1'b1;

      // reset state
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_pending", 64'(pending), 64'd0);
      chk("rst_drop", 64'(drop_cnt), 64'd0);
      chk("rst_out", {out_ch, out_q, out_ts}, 64'd0);

      // 1: single result, latency and timestamp
      guard = 0;
      while (m_ts != 10 && guard < 50) begin tick(); guard++; end
      chk("t1_ts_reach", 64'(guard < 50), 64'd1);
      q_valid = 4'b0100; set_q(2, -5);
      tick();
      q_valid = '0;
      tick();
      chk("t1_valid", 64'(out_valid), 64'd1);
      chk("t1_ch", 64'(out_ch), 64'd2);
      chk("t1_q", 64'(out_q), 64'(q31(-5)));
      chk("t1_ts", 64'(out_ts), 64'd10);
      tick();
      chk("t1_valid_low", 64'(out_valid), 64'd0);

      // 2: all channels at once, rr order 1,2,3,0 back-to-back
      do_reset();
      q_valid = 4'hF;
      for (int i = 0; i < N; i++) set_q(i, 100 + i);
      tick();
      q_valid = '0;
      chs[0] = 1; chs[1] = 2; chs[2] = 3; chs[3] = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("t2_valid", 64'(out_valid), 64'd1);
         chk("t2_ch", 64'(out_ch), 64'(chs[k]));
         chk("t2_q", 64'(out_q), 64'(100 + chs[k]));
      end
      tick();
      chk("t2_gap_end", 64'(out_valid), 64'd0);
      q_valid = 4'b0011; set_q(0, 7); set_q(1, 8);
      tick();
      q_valid = '0;
      tick();
      chk("t2_next_rr", 64'(out_ch), 64'd1);
      tick(); tick();

      // 3: output stalled, slot fills, third result dropped
      do_reset();
      out_ready = 1'b0;
      for (int c = 0; c < 7; c++) begin
         q_valid = (c % 3 == 0) ? 4'b0010 : 4'b0000;
         set_q(1, 11 * (c / 3 + 1));
         tick();
      end
      q_valid = '0;
      chk("t3_pending", 64'(pending), 64'h2);
      chk("t3_drop1", 64'(drop_cnt[C +: C]), 64'd1);
      chk("t3_out_q", 64'(out_q), 64'd11);
      check_state("t3");
      hs0 = hs_cnt;
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) tick();
      chk("t3_words", 64'(hs_cnt - hs0), 64'd2);

      // 4: drop counter saturation, then clear together with a drop
      do_reset();
      out_ready = 1'b0;
      q_valid = 4'b0001;
      for (int k = 0; k < 65536; k++) tick();
      chk("t4_before_sat", 64'(drop_cnt[0 +: C]), 64'd65534);
      for (int k = 0; k < 10; k++) tick();
      chk("t4_sat", 64'(drop_cnt[0 +: C]), 64'd65535);
      check_state("t4");
      clr_stats = 1'b1;
      tick();
      clr_stats = 1'b0;
      q_valid = '0;
      chk("t4_clr", 64'(drop_cnt[0 +: C]), 64'd0);

      // 5: enable=0 ignores q_valid but slots keep draining
      do_reset();
      out_ready = 1'b0;
      q_valid = 4'b0001; set_q(0, 55);
      tick();
      set_q(0, 66);
      tick();
      q_valid = '0;
      tick();
      chk("t5_pend0", 64'(pending), 64'h1);
      enable = 1'b0; out_ready = 1'b1; hs0 = hs_cnt;
      for (int k = 0; k < 6; k++) begin
         q_valid = (k % 2 == 0) ? 4'b1000 : 4'b0000;
         tick();
      end
      q_valid = '0;
      chk("t5_pending", 64'(pending), 64'd0);
      chk("t5_drop3", 64'(drop_cnt[3*C +: C]), 64'd0);
      chk("t5_words", 64'(hs_cnt - hs0), 64'd2);
      enable = 1'b1;

      // 6: reset while busy
      do_reset();
      out_ready = 1'b0;
      q_valid = 4'b0010;
      tick();
      q_valid = 4'b1010;
      tick();
      q_valid = '0;
      chk("t6_pre_pending", 64'(pending), 64'hA);
      chk("t6_pre_valid", 64'(out_valid), 64'd1);
      do_reset();
      chk("t6_valid", 64'(out_valid), 64'd0);
      chk("t6_pending", 64'(pending), 64'd0);
      tick(); tick(); tick();
      out_ready = 1'b1;
      q_valid = 4'b0100; set_q(2, 7);
      tick();
      q_valid = '0;
      tick();
      chk("t6_ts", 64'(out_ts), 64'd3);
      chk("t6_q", 64'(out_q), 64'd7);
      tick();

      // randomized phase against the model
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         enable    = ($urandom_range(0, 9) != 0);
         q_valid   = N'($urandom) & N'($urandom);
         for (int i = 0; i < N; i++) set_q(i, int'($urandom));
         out_ready = ($urandom_range(0, 3) != 0);
         clr_stats = ($urandom_range(0, 99) == 0);
         tick();
         check_state("rnd");
      end
      q_valid = '0; clr_stats = 1'b0; out_ready = 1'b1; enable = 1'b1;
      for (int k = 0; k < 10; k++) tick();
      chk("rnd_drained", 64'(exp_q.size()), 64'd0);
      check_state("rnd_end");

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
